// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Takes four static active-low segment patterns, double-buffers them and
//   only swaps the displayed value at frame boundaries (end of digit 3), so a
//   frame never mixes old and new digits.
//
//   Optional build macro: BLANK_GAP_EN
//     When defined, the first GAP cycles of every digit slot are blanked
//     (all anodes and segments off) to suppress ghosting between digits.
//
// Ports
//   clk        : clock, everything registered on posedge
//   rst        : synchronous active-high reset (priority over load_i)
//   load_i     : 1-cycle strobe capturing first_i..fourth_i
//   first_i    : pattern for leftmost digit (an_o[3]), active-low
//   second_i   : pattern for digit 2, active-low
//   third_i    : pattern for digit 3, active-low
//   fourth_i   : pattern for rightmost digit (an_o[0]), active-low
//   seg_o      : shared segment bus, active-low, registered
//   an_o       : active-low one-hot digit enables, registered
//   frame_o    : pulse on the first output cycle of digit 0 after a wrap
//   pending_o  : a loaded pattern set is waiting for the next boundary
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16,
  parameter int GAP         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [6:0] first_i,
  input  logic [6:0] second_i,
  input  logic [6:0] third_i,
  input  logic [6:0] fourth_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       frame_o,
  output logic       pending_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [3:0]       AN_OFF   = 4'hF;

  // Reject parameter sets that would make the slot counter or dead time
  // meaningless.
  if (REFRESH_DIV < 2 || GAP >= REFRESH_DIV || (64'd1 << CNT_W) < 64'(REFRESH_DIV))
  begin : g_bad_params
    $error("seven_seg_scanner: illegal REFRESH_DIV/CNT_W/GAP combination");
  end

  // Digit-indexed views: index 0 is the leftmost digit.
  logic [3:0][6:0] in_pat;
  assign in_pat = {fourth_i, third_i, second_i, first_i};

  // State registers
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic [3:0][6:0]  active_reg, active_next;
  logic [3:0][6:0]  pending_reg, pending_next;
  logic             pending_valid_reg, pending_valid_next;
  // Set at the first boundary after reset; keeps frame_o quiet for frame 0.
  logic             frame_seen_reg, frame_seen_next;

  // Output registers
  logic [6:0] seg_reg, seg_next;
  logic [3:0] an_reg, an_next;
  logic       frame_reg, frame_next;

  logic       at_last;
  logic       boundary;
  logic [3:0] an_dec;

  assign at_last  = (cnt_reg == CNT_LAST);
  assign boundary = at_last && (idx_reg == 2'd3);

  // an_o[3] belongs to digit 0, an_o[0] to digit 3.
  for (genvar gi = 0; gi < 4; gi++) begin : g_an_dec
    assign an_dec[gi] = (idx_reg != 2'(3 - gi));
  end

  always_comb begin
    cnt_next           = cnt_reg;
    idx_next           = idx_reg;
    active_next        = active_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;
    frame_seen_next    = frame_seen_reg | boundary;
    seg_next           = active_reg[idx_reg];
    an_next            = an_dec;
    frame_next         = frame_seen_reg && (cnt_reg == '0) && (idx_reg == 2'd0);

    if (at_last) begin
      cnt_next = '0;
      idx_next = idx_reg + 2'd1;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end

    if (boundary) begin
      // A load landing on the boundary goes straight to the active buffer
      // and supersedes anything still pending.
      if (load_i) begin
        active_next        = in_pat;
        pending_valid_next = 1'b0;
      end else if (pending_valid_reg) begin
        active_next        = pending_reg;
        pending_valid_next = 1'b0;
      end
    end else if (load_i) begin
      pending_next       = in_pat;
      pending_valid_next = 1'b1;
    end

`ifdef BLANK_GAP_EN
    if (cnt_reg < CNT_W'(GAP)) begin
      seg_next = SEG_OFF;
      an_next  = AN_OFF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg           <= '0;
      idx_reg           <= 2'd0;
      active_reg        <= {4{SEG_OFF}};
      pending_reg       <= {4{SEG_OFF}};
      pending_valid_reg <= 1'b0;
      frame_seen_reg    <= 1'b0;
      seg_reg           <= SEG_OFF;
      an_reg            <= AN_OFF;
      frame_reg         <= 1'b0;
    end else begin
      cnt_reg           <= cnt_next;
      idx_reg           <= idx_next;
      active_reg        <= active_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
      frame_seen_reg    <= frame_seen_next;
      seg_reg           <= seg_next;
      an_reg            <= an_next;
      frame_reg         <= frame_next;
    end
  end

  assign seg_o     = seg_reg;
  assign an_o      = an_reg;
  assign frame_o   = frame_reg;
  assign pending_o = pending_valid_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//   Directed plus random stimulus for seven_seg_scanner with REFRESH_DIV=4.
//   The reference model works in terms of absolute cycle position since reset:
//   digit = (pos / DIV) % 4, frame = pos / (4*DIV); buffers swap at the last
//   cycle of each frame.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int DIV   = 4;
  localparam int CW    = 3;
  localparam int GAPC  = 1;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_i;
  logic [6:0] first_i, second_i, third_i, fourth_i;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       frame_o;
  logic       pending_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         pos;
  logic [6:0] m_act  [4];
  logic [6:0] m_pend [4];
  logic       m_valid;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .CNT_W(CW), .GAP(GAPC)) dut (
    .clk(clk), .rst(rst), .load_i(load_i),
    .first_i(first_i), .second_i(second_i), .third_i(third_i), .fourth_i(fourth_i),
    .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s pos=%0d observed=%h expected=%h", tag, pos, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model, check outputs #1 after the edge.
  task automatic step(input logic r, input logic ld,
                      input logic [6:0] a, input logic [6:0] b,
                      input logic [6:0] c, input logic [6:0] d);
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_frame;
    logic [6:0] inp [4];
    int         digit;
    inp[0] = a; inp[1] = b; inp[2] = c; inp[3] = d;
    rst = r; load_i = ld;
    first_i = a; second_i = b; third_i = c; fourth_i = d;
    @(posedge clk);
    if (r) begin
      e_seg = 7'h7F; e_an = 4'hF; e_frame = 1'b0;
      for (int k = 0; k < 4; k++) begin m_act[k] = 7'h7F; m_pend[k] = 7'h7F; end
      m_valid = 1'b0;
      pos = 0;
    end else begin
      digit   = (pos / DIV) % 4;
      e_an    = 4'b1111 ^ (4'b1000 >> digit);
      e_seg   = m_act[digit];
      e_frame = (pos % FRAME == 0) && (pos >= FRAME);
`ifdef BLANK_GAP_EN
      if (pos % DIV < GAPC) begin e_an = 4'hF; e_seg = 7'h7F; end
`endif
      if (pos % FRAME == FRAME - 1) begin
        if (ld) begin
          for (int k = 0; k < 4; k++) m_act[k] = inp[k];
          m_valid = 1'b0;
        end else if (m_valid) begin
          for (int k = 0; k < 4; k++) m_act[k] = m_pend[k];
          m_valid = 1'b0;
        end
      end else if (ld) begin
        for (int k = 0; k < 4; k++) m_pend[k] = inp[k];
        m_valid = 1'b1;
      end
    end
    #1;
    check("seg_o",     {1'b0, seg_o},  {1'b0, e_seg});
    check("an_o",      {4'b0, an_o},   {4'b0, e_an});
    check("frame_o",   {7'b0, frame_o},   {7'b0, e_frame});
    check("pending_o", {7'b0, pending_o}, {7'b0, m_valid});
    if (!r) pos++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00);
  endtask

  // Idle until the next edge happens at frame position target (at most one frame).
  task automatic idle_until(input int target);
    for (int k = 0; k < FRAME && (pos % FRAME) != target; k++) idle(1);
  endtask

  initial begin
    pos = 0; m_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin m_act[k] = 7'h7F; m_pend[k] = 7'h7F; end

    // 1: reset for 3 cycles, then release
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00);
    idle(1);
    check("first_an_after_reset", {4'b0, an_o}, 8'h07);

    // 2: load mid-frame, watch pending and the next frame
    idle(1);
    step(1'b0, 1'b1, 7'h40, 7'h79, 7'h24, 7'h30);
    idle(2 * FRAME + 2);

    // 3: two loads in one frame, last wins
    idle_until(1);
    step(1'b0, 1'b1, 7'h40, 7'h40, 7'h40, 7'h40);
    idle(3);
    step(1'b0, 1'b1, 7'h12, 7'h12, 7'h12, 7'h12);
    idle(FRAME + 4);

    // 4: load exactly in the boundary cycle
    idle_until(FRAME - 1);
    step(1'b0, 1'b1, 7'h79, 7'h79, 7'h79, 7'h79);
    check("pending_after_boundary_load", {7'b0, pending_o}, 8'h00);
    idle(FRAME + 2);

    // 5: pending load then reset at idx 2
    idle_until(1);
    step(1'b0, 1'b1, 7'h55, 7'h2A, 7'h55, 7'h2A);
    idle_until(2 * DIV + 1);
    step(1'b1, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00);
    step(1'b1, 1'b1, 7'h01, 7'h02, 7'h03, 7'h04);
    idle(2 * FRAME + 2);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 97) == 0, ($urandom % 6) == 0,
           7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
